hci_core_sequencer: RTL and testbench
=====================================

HCI_CORE_SEQUENCER -- requirements
Module: hci_core_sequencer

Interface
REQ-001 SHALL have parameter DW, default hci_package::DEFAULT_DW, the TCDM data width in bits, a multiple of 32.
REQ-002 SHALL have parameter AW, default hci_package::DEFAULT_AW, the byte-address width.
REQ-003 SHALL have parameter LEN_W, default 16, the width of the transfer-length field.
REQ-004 SHALL have parameter RBUF_DEPTH, default 2, the read-buffer depth (>=2).
REQ-005 SHALL have the ports below, clock and reset first: one clock; reset is synchronous and active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  starts a transfer (sampled in IDLE).
- base_addr_i  in  AW  byte address of word 0.
- stride_i  in  AW  byte stride between words.
- len_i  in  LEN_W  number of words.
- wen_i  in  1  1=read, 0=write (TCDM convention).
- wdata_valid_i, wdata_ready_o  in/out  1  write-stream handshake.
- wdata_i  in  DW  write word.
- rdata_valid_o, rdata_ready_i  out/in  1  read-stream handshake.
- rdata_o  out  DW  read word.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle completion pulse.
- tcdm  hci_core_intf.master  -  wide TCDM port toward hci_router.

Function
REQ-006 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE; DONE lasts one cycle and then returns to IDLE.
REQ-007 In IDLE with start_i=1: SHALL latch base, stride, len and wen, clear the word counter k, and enter ISSUE; start_i outside IDLE SHALL be ignored.
REQ-008 start with len_i=0 SHALL go IDLE->DONE without asserting tcdm.req.
REQ-009 tcdm.add SHALL equal base + k*stride modulo 2^AW, computed by running accumulation (no multiplier).
REQ-010 tcdm.be SHALL be all ones; tcdm.wen = the latched wen; tcdm.data = wdata_i; tcdm.user = '0.
REQ-011 Write transfers: tcdm.req = wdata_valid_i in ISSUE; wdata_ready_o = tcdm.req & tcdm.gnt.
REQ-012 Read transfers: tcdm.req SHALL be high in ISSUE only when credits>0.
- credits = RBUF_DEPTH - rbuf occupancy - outstanding.
- outstanding is 1 in the cycle after a granted read, else 0.
REQ-013 Once asserted, req and all its payload SHALL stay stable until gnt.
REQ-014 On req&gnt, k SHALL increment; the grant of word len-1 SHALL move the FSM to DONE (write) or DRAIN (read).
REQ-015 A read response SHALL be accepted only when tcdm.r_valid is high and the registered (req&gnt&wen) from the previous cycle is high.
- An accepted response pushes r_data into the rbuf.
- r_valid without a prior grant SHALL be ignored.
REQ-016 rdata_valid_o = rbuf not empty; rdata_o = rbuf head; pop on rdata_valid_o&rdata_ready_i; push and pop in the same cycle SHALL be legal at any occupancy.
REQ-017 DRAIN SHALL exit to DONE when outstanding=0 and the rbuf is empty.
REQ-018 The rbuf SHALL never overflow by construction; the rbuf SHALL NOT be sized by rdata_ready_i.
REQ-019 clear_i SHALL return the FSM to IDLE within one cycle.
- It flushes the rbuf, zeroes outstanding and k, and suppresses done_o.
- clear_i has priority over start_i.

Reset
REQ-020 On rst_ni=0 at a clock edge, the block SHALL enter IDLE with an empty rbuf and outstanding=0.
REQ-021 During reset, outputs SHALL be: tcdm.req=0, wdata_ready_o=0, rdata_valid_o=0, busy_o=0, done_o=0, rdata_o='0.
REQ-022 Reset in mid-transfer SHALL abandon the transfer; late r_valid responses SHALL be ignored per REQ-015.

Structure
REQ-023 The state enum hci_seq_state_t SHALL live in hci_package.
REQ-024 The rbuf SHALL be one sub-module, hci_core_sequencer_rbuf: a synchronous FIFO of RBUF_DEPTH words with an occupancy output.

Verification
REQ-025 Write, base=0x100, stride=16, len=4, gnt always 1, wdata always valid.
- Required: addresses 0x100/0x110/0x120/0x130 in 4 consecutive cycles.
- Required: done_o in the 5th cycle.
REQ-026 Read, len=3, gnt=1, r_valid one cycle after each gnt, rdata_ready_i=0.
- Required: 2 requests, then req=0 (credits exhausted).
- Required: raising ready releases the 3rd request; data arrives in order; done after the last pop.
REQ-027 Read with gnt held low 3 cycles on word 1.
- Required: add/wen stay stable.
- Required: k does not advance; no spurious rbuf push.
REQ-028 start with len=0 -> done_o after 1 cycle, no req; start_i pulsed during ISSUE -> no effect.
REQ-029 Wrap: base=0xFFFF_FFF0, stride=16, len=2, AW=32 -> addresses 0xFFFF_FFF0, 0x0000_0000.
REQ-030 clear_i in DRAIN with 1 word buffered -> IDLE next cycle, rdata_valid_o=0, no done_o.

Source files
------------

// File: rtl/hci_core_sequencer_pkg.sv
// Shared defaults, sequencer state type and helpers for the HCI core sequencer slice.
package hci_package;

    localparam int unsigned DEFAULT_DW = 32;
    localparam int unsigned DEFAULT_AW = 32;
    localparam int unsigned DEFAULT_UW = 1;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DRAIN,
        SEQ_DONE
    } hci_seq_state_t;

    // Pointer width for a buffer of n entries; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hci_core_sequencer_if.sv
// Wide TCDM request/response port shared between the sequencer (master) and hci_router (slave).
interface hci_core_intf
    import hci_package::*;
#(
    parameter int unsigned DW = DEFAULT_DW,
    parameter int unsigned AW = DEFAULT_AW,
    parameter int unsigned UW = DEFAULT_UW
) ();

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [UW-1:0]   user;
    logic [DW-1:0]   r_data;
    logic            r_valid;

    modport master (
        output req, add, wen, data, be, user,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, data, be, user,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/hci_core_sequencer_rbuf.sv
// Read-response buffer: synchronous FIFO of DEPTH words with occupancy output.
module hci_core_sequencer_rbuf
    import hci_package::*;
#(
    parameter int unsigned DW    = DEFAULT_DW,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = ptr_width(DEPTH),
    localparam int unsigned OW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          empty_o,
    output logic [OW-1:0] occ_o
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [OW-1:0] r_occ;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = pop_i & (r_occ != '0);
    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign w_push = push_i & ((r_occ != OW'(DEPTH)) | w_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

    assign data_o  = r_mem[r_rptr];
    assign empty_o = (r_occ == '0);
    assign occ_o   = r_occ;

endmodule

// File: rtl/hci_core_sequencer.sv
// Strided TCDM sequencer: issues len word accesses at base + k*stride, streaming
// write data in and read data out through a credit-limited response buffer.
module hci_core_sequencer
    import hci_package::*;
#(
    parameter int unsigned DW         = DEFAULT_DW,
    parameter int unsigned AW         = DEFAULT_AW,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned RBUF_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [AW-1:0]    base_addr_i,
    input  logic [AW-1:0]    stride_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             wen_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [DW-1:0]    wdata_i,
    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic [DW-1:0]    rdata_o,
    output logic             busy_o,
    output logic             done_o,
    hci_core_intf.master     tcdm
);

    localparam int unsigned OW = $clog2(RBUF_DEPTH + 1);

    hci_seq_state_t   r_state;
    hci_seq_state_t   w_state_nxt;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_stride;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_k;
    logic             r_wen;
    logic             r_out;
    logic             w_req;
    logic             w_hs;
    logic             w_last;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [DW-1:0]    w_head;
    logic [OW-1:0]    w_occ;
    logic [OW:0]      w_used;

    assign w_used = {1'b0, w_occ} + {{OW{1'b0}}, r_out};
    assign w_last = (r_k == r_len - 1'b1);
    assign w_hs   = w_req & tcdm.gnt;
    // Only a response in the cycle right after a read grant is genuine.
    assign w_push = tcdm.r_valid & r_out;
    assign w_pop  = ~w_empty & rdata_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= SEQ_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (start_i) w_state_nxt = (len_i == '0) ? SEQ_DONE : SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                w_req = r_wen ? (32'(w_used) < RBUF_DEPTH) : wdata_valid_i;
                if (w_req && tcdm.gnt && w_last) w_state_nxt = r_wen ? SEQ_DRAIN : SEQ_DONE;
            end
            SEQ_DRAIN: begin
                if (!r_out && w_empty) w_state_nxt = SEQ_DONE;
            end
            SEQ_DONE: w_state_nxt = SEQ_IDLE;
            default:  w_state_nxt = SEQ_IDLE;
        endcase
        if (clear_i) w_state_nxt = SEQ_IDLE;
    end

    // Address advances by accumulation so no multiplier is needed.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_len    <= '0;
            r_k      <= '0;
            r_wen    <= 1'b0;
            r_out    <= 1'b0;
        end else if (clear_i) begin
            r_k   <= '0;
            r_out <= 1'b0;
        end else begin
            r_out <= w_hs & r_wen;
            if (r_state == SEQ_IDLE && start_i) begin
                r_addr   <= base_addr_i;
                r_stride <= stride_i;
                r_len    <= len_i;
                r_wen    <= wen_i;
                r_k      <= '0;
            end else if (w_hs) begin
                r_k    <= r_k + 1'b1;
                r_addr <= r_addr + r_stride;
            end
        end
    end

    hci_core_sequencer_rbuf #(
        .DW    (DW),
        .DEPTH (RBUF_DEPTH)
    ) u_rbuf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (w_push),
        .data_i  (tcdm.r_data),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .empty_o (w_empty),
        .occ_o   (w_occ)
    );

    assign tcdm.req      = w_req;
    assign tcdm.add      = r_addr;
    assign tcdm.wen      = r_wen;
    assign tcdm.data     = wdata_i;
    assign tcdm.be       = '1;
    assign tcdm.user     = '0;

    assign wdata_ready_o = w_hs & ~r_wen;
    assign rdata_valid_o = ~w_empty;
    assign rdata_o       = w_empty ? '0 : w_head;
    assign busy_o        = (r_state != SEQ_IDLE);
    assign done_o        = (r_state == SEQ_DONE) & ~clear_i;

endmodule

// File: tb/tb_hci_core_sequencer.sv
// Self-checking bench for hci_core_sequencer: TCDM slave responder, queue-based
// reference model checked every cycle, directed scenarios and randomized traffic.
module tb_hci_core_sequencer;
    import hci_package::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = 16;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, clear, start, wen, wvalid, rready;
    logic [AW-1:0] base, stride;
    logic [LW-1:0] len;
    logic [DW-1:0] wdata, rdata;
    logic          wready, rvalid, busy, done;

    hci_core_intf #(.DW(DW), .AW(AW)) tcdm_if ();

    hci_core_sequencer #(
        .DW(DW), .AW(AW), .LEN_W(LW), .RBUF_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
        .base_addr_i(base), .stride_i(stride), .len_i(len), .wen_i(wen),
        .wdata_valid_i(wvalid), .wdata_ready_o(wready), .wdata_i(wdata),
        .rdata_valid_o(rvalid), .rdata_ready_i(rready), .rdata_o(rdata),
        .busy_o(busy), .done_o(done), .tcdm(tcdm_if)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: phase 0=idle 1=issuing 2=draining 3=done
    int            m_phase = 0;
    logic [AW-1:0] m_base, m_stride;
    int            m_len, m_k;
    logic          m_wen;
    bit            m_out = 0;
    bit            m_ok  = 0;
    logic [DW-1:0] m_q[$];
    bit            exp_req;

    // Slave responder and observation logs
    bit            resp_pend = 0;
    logic [DW-1:0] resp_data;
    bit            spur_en = 0, force_rv = 0, hold_w = 0;
    logic [AW-1:0] hs_addr_q[$];
    int            hs_cyc_q[$];
    logic [DW-1:0] pop_q[$];
    int            last_pop_cyc, done_cnt, done_cyc;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        int            used;
        logic [AW-1:0] ea;
        logic [DW-1:0] erd;
        used    = m_q.size() + int'(m_out);
        exp_req = (m_phase == 1) && (m_wen ? (used < int'(DEPTH)) : (wvalid === 1'b1));
        erd     = '0;
        if (m_q.size() != 0) erd = m_q[0];
        chk("req", tcdm_if.req, exp_req);
        chk("busy", busy, m_phase != 0);
        chk("done", done, (m_phase == 3) && !clear);
        chk("wdata_ready", wready, exp_req && tcdm_if.gnt && !m_wen);
        chk("rdata_valid", rvalid, m_q.size() != 0);
        chk("rdata", rdata, erd);
        if (exp_req && tcdm_if.req === 1'b1) begin
            ea = m_base + AW'(m_k) * m_stride;
            chk("add", tcdm_if.add, ea);
            chk("wen", tcdm_if.wen, m_wen);
            chk("be", tcdm_if.be, 4'hF);
            chk("wdata", tcdm_if.data, wdata);
            chk("user", tcdm_if.user, 0);
        end
    endtask

    task automatic model_update();
        bit            pop, push, new_out, drain_exit;
        logic [DW-1:0] pd;
        if (!rst_n || clear) begin
            m_phase = 0;
            m_q.delete();
            m_out = 0;
            m_k   = 0;
        end else begin
            pop        = (m_q.size() != 0) && rready;
            push       = (tcdm_if.r_valid === 1'b1) && m_out;
            pd         = tcdm_if.r_data;
            new_out    = exp_req && tcdm_if.gnt && m_wen;
            drain_exit = !m_out && (m_q.size() == 0);
            case (m_phase)
                0: if (start) begin
                    m_base = base; m_stride = stride; m_len = int'(len); m_wen = wen; m_k = 0;
                    m_phase = (m_len == 0) ? 3 : 1;
                end
                1: if (exp_req && tcdm_if.gnt) begin
                    m_k++;
                    if (m_k == m_len) m_phase = m_wen ? 2 : 3;
                end
                2: if (drain_exit) m_phase = 3;
                default: m_phase = 0;
            endcase
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(pd);
            m_out = new_out;
        end
        m_ok = 1;
    endtask

    // One clock cycle: drive slave response, check, log, advance model.
    task automatic step();
        bit            hs, hw;
        logic [AW-1:0] ha;
        if (resp_pend) begin
            tcdm_if.r_valid = 1'b1; tcdm_if.r_data = resp_data;
        end else if (force_rv || (spur_en && $urandom_range(0, 3) == 0)) begin
            tcdm_if.r_valid = 1'b1; tcdm_if.r_data = $urandom;
        end else begin
            tcdm_if.r_valid = 1'b0; tcdm_if.r_data = $urandom;
        end
        #1;
        if (m_ok) compare();
        hs = (tcdm_if.req === 1'b1) && (tcdm_if.gnt === 1'b1);
        hw = (tcdm_if.wen === 1'b1);
        ha = tcdm_if.add;
        if (hs) begin hs_addr_q.push_back(ha); hs_cyc_q.push_back(cyc); end
        if (rvalid === 1'b1 && rready) begin pop_q.push_back(rdata); last_pop_cyc = cyc; end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        hold_w = (tcdm_if.req === 1'b1) && (tcdm_if.gnt !== 1'b1) && !hw;
        @(posedge clk);
        model_update();
        resp_pend = hs && hw;
        resp_data = mem_data(ha);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clr_logs();
        hs_addr_q.delete(); hs_cyc_q.delete(); pop_q.delete();
        done_cnt = 0; done_cyc = -1; last_pop_cyc = -1;
    endtask

    task automatic launch(input logic w, input logic [AW-1:0] b, input logic [AW-1:0] s, input int l);
        wen = w; base = b; stride = s; len = LW'(l); clear = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_idle(input int max, input string name);
        int n;
        n = 0;
        while ((m_phase != 0 || busy !== 1'b0) && n < max) begin step(); n++; end
        chk({name, "_timeout"}, n < max, 1);
    endtask

    task automatic rand_drive();
        tcdm_if.gnt = ($urandom_range(0, 9) < 7);
        rready      = $urandom_range(0, 1);
        clear       = ($urandom_range(0, 49) == 0);
        start       = ($urandom_range(0, 9) == 0);
        wen         = $urandom_range(0, 1);
        base        = $urandom;
        len         = LW'($urandom_range(0, 6));
        if (!hold_w) begin wvalid = $urandom_range(0, 1); wdata = $urandom; end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_assert=%0d", n_assert);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; wen = 1'b0; wvalid = 1'b0; rready = 1'b0;
        base = '0; stride = '0; len = '0; wdata = 32'hDEAD_0001;
        tcdm_if.gnt = 1'b0; tcdm_if.r_valid = 1'b0; tcdm_if.r_data = '0;
        clr_logs();
        @(negedge clk);

        // Reset state
        step(); step();
        chk("rst_req", tcdm_if.req, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        step();

        // Write burst, back-to-back grants
        clr_logs(); tcdm_if.gnt = 1'b1; wvalid = 1'b1;
        begin
            int c0;
            c0 = cyc;
            launch(1'b0, 32'h100, 32'd16, 4);
            run_idle(20, "wr4");
            chk("wr4_count", hs_addr_q.size(), 4);
            for (int i = 0; i < 4 && i < hs_addr_q.size(); i++) begin
                chk("wr4_addr", hs_addr_q[i], 32'h100 + 32'(i) * 32'h10);
                chk("wr4_cycle", hs_cyc_q[i], c0 + 1 + i);
            end
            chk("wr4_done_cycle", done_cyc, c0 + 5);
            chk("wr4_done_count", done_cnt, 1);
        end

        // Read burst with credit stall
        clr_logs(); wvalid = 1'b0; rready = 1'b0;
        launch(1'b1, 32'h2000, 32'd8, 3);
        for (int i = 0; i < 4; i++) step();
        chk("rd3_req_before_stall", hs_addr_q.size(), 2);
        chk("rd3_stalled_req", tcdm_if.req, 0);
        rready = 1'b1;
        run_idle(30, "rd3");
        chk("rd3_count", hs_addr_q.size(), 3);
        chk("rd3_pops", pop_q.size(), 3);
        for (int i = 0; i < 3 && i < pop_q.size(); i++)
            chk("rd3_data", pop_q[i], mem_data(32'h2000 + 32'(i) * 32'd8));
        chk("rd3_done_after_pop", done_cyc > last_pop_cyc, 1);
        chk("rd3_done_count", done_cnt, 1);

        // Grant withheld on word 1, spurious r_valid while stalled
        clr_logs();
        launch(1'b1, 32'h3000, 32'd4, 3);
        step();
        tcdm_if.gnt = 1'b0; force_rv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", tcdm_if.req, 1);
            chk("stall_add", tcdm_if.add, 32'h3004);
            chk("stall_wen", tcdm_if.wen, 1);
            step();
        end
        chk("stall_k_hold", hs_addr_q.size(), 1);
        tcdm_if.gnt = 1'b1; force_rv = 1'b0;
        run_idle(30, "stall");
        chk("stall_pops", pop_q.size(), 3);
        for (int i = 0; i < 3 && i < pop_q.size(); i++)
            chk("stall_data", pop_q[i], mem_data(32'h3000 + 32'(i) * 32'd4));

        // Zero length, then start pulsed mid-transfer
        clr_logs();
        begin
            int c0;
            c0 = cyc;
            launch(1'b0, 32'h40, 32'd4, 0);
            run_idle(10, "len0");
            chk("len0_no_req", hs_addr_q.size(), 0);
            chk("len0_done_cycle", done_cyc, c0 + 1);
        end
        clr_logs(); wvalid = 1'b0;
        launch(1'b0, 32'h500, 32'd4, 2);
        step();
        base = 32'h900; len = 16'd7; start = 1'b1;
        step();
        start = 1'b0; wvalid = 1'b1;
        run_idle(20, "restart");
        chk("restart_count", hs_addr_q.size(), 2);
        for (int i = 0; i < 2 && i < hs_addr_q.size(); i++)
            chk("restart_addr", hs_addr_q[i], 32'h500 + 32'(i) * 32'd4);
        chk("restart_done_count", done_cnt, 1);

        // Address wrap
        clr_logs();
        launch(1'b0, 32'hFFFF_FFF0, 32'd16, 2);
        run_idle(20, "wrap");
        chk("wrap_count", hs_addr_q.size(), 2);
        if (hs_addr_q.size() == 2) begin
            chk("wrap_addr0", hs_addr_q[0], 32'hFFFF_FFF0);
            chk("wrap_addr1", hs_addr_q[1], 32'h0000_0000);
        end

        // Clear while draining with one buffered word
        clr_logs(); wvalid = 1'b0; rready = 1'b0;
        launch(1'b1, 32'h700, 32'd4, 1);
        step(); step();
        chk("clr_buffered", rvalid, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_rvalid", rvalid, 0);
        step(); step();
        chk("clr_no_done", done_cnt, 0);

        // Reset mid-transfer, late response must be ignored
        clr_logs(); rready = 1'b1;
        launch(1'b1, 32'h800, 32'd4, 4);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rvalid", rvalid, 0);
        chk("rstmid_no_done", done_cnt, 0);

        // Randomized traffic
        spur_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            rand_drive();
            stride = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8)) * 32'd4;
            launch($urandom_range(0, 1), $urandom, stride, $urandom_range(0, 6));
            run_idle_rand: begin
                int n;
                n = 0;
                while ((m_phase != 0 || busy !== 1'b0) && n < 300) begin
                    rand_drive();
                    step();
                    n++;
                end
                chk("rand_timeout", n < 300, 1);
            end
        end
        clear = 1'b0; start = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
